clk_enable_gen: RTL and testbench

Parametrised multi-channel clock-enable generator. From a single reference clock it produces `N_CH` independent rational-rate enable strobes and matching near-50%-duty divided clocks, using one phase accumulator per channel. Each channel has a runtime-reprogrammable increment, glitch-free retune at the channel's wrap point, and per-channel plus aggregate lock status. It sits next to the fixed-frequency PLL wrappers and serves logic that needs frequencies or retuning that a PLL output set cannot provide.

---
 rtl/clk_enable_gen_pkg.sv | 17 +
 rtl/clk_enable_gen_if.sv | 20 ++
 rtl/clk_enable_gen_nco_channel.sv | 90 +++++++++
 rtl/clk_enable_gen.sv | 67 ++++++
 tb/tb_clk_enable_gen.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/clk_enable_gen_pkg.sv
// Shared defaults, increment type and frequency-to-increment helper for clk_enable_gen.
// Pure declarations; no logic.
package clk_gen_pkg;

  localparam int ACC_W_DEF      = 24;
  localparam int LOCK_WRAPS_DEF = 4;

  typedef logic [ACC_W_DEF-1:0] inc_t;

  // Round-to-nearest of out_hz * 2^acc_w / ref_hz.
  function automatic longint unsigned freq_to_inc(input longint unsigned ref_hz,
                                                  input longint unsigned out_hz,
                                                  input int unsigned     acc_w);
    return ((out_hz << acc_w) + (ref_hz >> 1)) / ref_hz;
  endfunction

endpackage

// File: rtl/clk_enable_gen_if.sv
// Configuration channel of clk_enable_gen: valid/ready increment write plus error pulse.
// Master drives the request; slave returns ready and the out-of-range error.
interface clk_enable_gen_if #(
  parameter int N_CH  = 2,
  parameter int ACC_W = clk_gen_pkg::ACC_W_DEF
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [ACC_W-1:0] cfg_inc;
  logic             cfg_err;

  modport master (output cfg_valid, output cfg_ch, output cfg_inc,
                  input  cfg_ready, input  cfg_err);
  modport slave  (input  cfg_valid, input  cfg_ch, input  cfg_inc,
                  output cfg_ready, output cfg_err);

endinterface

// File: rtl/clk_enable_gen_nco_channel.sv
// One phase-accumulator channel: registered ce/clk outputs, pending increment slot applied at wrap.
// Lock counts wraps at a settled increment; a new write restarts the count.
module nco_channel
  import clk_gen_pkg::*;
#(
  parameter int               ACC_W      = ACC_W_DEF,
  parameter int               LOCK_WRAPS = LOCK_WRAPS_DEF,
  parameter logic [ACC_W-1:0] INC_RST    = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_i,
  input  logic [ACC_W-1:0] wr_inc_i,
  output logic             pend_v_o,
  output logic             ce_o,
  output logic             clk_o,
  output logic             locked_o
);

  localparam int               CNT_W    = $clog2(LOCK_WRAPS + 1);
  localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(LOCK_WRAPS);

  logic [ACC_W-1:0] acc_q, acc_d, inc_q, inc_d, pend_inc_q, pend_inc_d;
  logic             pend_v_q, pend_v_d, ce_q, ce_d, clk_q, clk_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic [ACC_W:0]   sum;
  logic             enabled, carry, apply;

  always_comb begin
    sum        = {1'b0, acc_q} + {1'b0, inc_q};
    enabled    = |inc_q;
    carry      = sum[ACC_W];
    // Swapping only at the wrap keeps every ce/clk phase full length.
    apply      = pend_v_q && (carry || !enabled);
    acc_d      = acc_q;
    inc_d      = inc_q;
    pend_inc_d = pend_inc_q;
    pend_v_d   = pend_v_q;
    lock_cnt_d = lock_cnt_q;
    ce_d       = 1'b0;
    clk_d      = 1'b0;
    if (enabled) begin
      acc_d = sum[ACC_W-1:0];
      ce_d  = carry;
      clk_d = sum[ACC_W-1];
    end
    if (apply) begin
      inc_d    = pend_inc_q;
      pend_v_d = 1'b0;
      if (pend_inc_q == '0) begin
        acc_d = '0;
        ce_d  = 1'b0;
        clk_d = 1'b0;
      end
    end
    if (carry && !pend_v_q && (lock_cnt_q != LOCK_MAX)) lock_cnt_d = lock_cnt_q + 1'b1;
    // Writes only arrive while the slot is empty, so they never collide with apply.
    if (wr_i) begin
      pend_inc_d = wr_inc_i;
      pend_v_d   = 1'b1;
      lock_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      inc_q      <= INC_RST;
      pend_inc_q <= '0;
      pend_v_q   <= 1'b0;
      lock_cnt_q <= '0;
      ce_q       <= 1'b0;
      clk_q      <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      inc_q      <= inc_d;
      pend_inc_q <= pend_inc_d;
      pend_v_q   <= pend_v_d;
      lock_cnt_q <= lock_cnt_d;
      ce_q       <= ce_d;
      clk_q      <= clk_d;
    end
  end

  assign pend_v_o = pend_v_q;
  assign ce_o     = ce_q;
  assign clk_o    = clk_q;
  assign locked_o = (lock_cnt_q == LOCK_MAX) && (|inc_q);

endmodule

// File: rtl/clk_enable_gen.sv
// Multi-channel rational clock-enable generator: channel decode, ready mux, error pulse, lock aggregate.
// Outputs are registered per channel; config ready drops only while the addressed channel has a pending write.
module clk_enable_gen
  import clk_gen_pkg::*;
#(
  parameter int                      N_CH       = 2,
  parameter int                      ACC_W      = ACC_W_DEF,
  parameter int                      LOCK_WRAPS = LOCK_WRAPS_DEF,
  parameter logic [N_CH*ACC_W-1:0]   INC_RST    = '0
) (
  input  logic                  refclk,
  input  logic                  rst_n,
  clk_enable_gen_if.slave       cfg,
  output logic [N_CH-1:0]       ce_o,
  output logic [N_CH-1:0]       clk_o,
  output logic [N_CH-1:0]       locked,
  output logic                  locked_all
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH-1:0] hit, pend_v, wr;
  logic            ready, in_range, xfer, cfg_err_q;

  // Out-of-range channels never match, leaving ready high so the request drains.
  always_comb begin
    hit   = '0;
    ready = 1'b1;
    for (int i = 0; i < N_CH; i++) begin
      if (cfg.cfg_ch == CH_W'(i)) begin
        hit[i] = 1'b1;
        ready  = !pend_v[i];
      end
    end
  end

  assign in_range = |hit;
  assign xfer     = cfg.cfg_valid && ready;
  assign wr       = xfer ? hit : '0;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) cfg_err_q <= 1'b0;
    else        cfg_err_q <= xfer && !in_range;
  end

  assign cfg.cfg_ready = ready;
  assign cfg.cfg_err   = cfg_err_q;
  assign locked_all    = &locked;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    nco_channel #(
      .ACC_W      (ACC_W),
      .LOCK_WRAPS (LOCK_WRAPS),
      .INC_RST    (INC_RST[c*ACC_W +: ACC_W])
    ) u_nco (
      .clk      (refclk),
      .rst_n    (rst_n),
      .wr_i     (wr[c]),
      .wr_inc_i (cfg.cfg_inc),
      .pend_v_o (pend_v[c]),
      .ce_o     (ce_o[c]),
      .clk_o    (clk_o[c]),
      .locked_o (locked[c])
    );
  end

endmodule

// File: tb/tb_clk_enable_gen.sv
// Bench for clk_enable_gen: 3 channels, 8-bit accumulator, directed retune/disable/reset steps plus random config traffic.
module tb_clk_enable_gen;
  import clk_gen_pkg::*;

  localparam int N = 3;
  localparam int W = 8;

  logic         refclk = 1'b0;
  logic         rst_n  = 1'b0;
  logic [N-1:0] ce_o, clk_o, locked;
  logic         locked_all;

  clk_enable_gen_if #(.N_CH(N), .ACC_W(W)) cfg_if ();

  clk_enable_gen #(
    .N_CH       (N),
    .ACC_W      (W),
    .LOCK_WRAPS (4),
    .INC_RST    ({8'd128, 8'd32, 8'd64})
  ) dut (
    .refclk     (refclk),
    .rst_n      (rst_n),
    .cfg        (cfg_if),
    .ce_o       (ce_o),
    .clk_o      (clk_o),
    .locked     (locked),
    .locked_all (locked_all)
  );

  always #5 refclk = ~refclk;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  bit ce0_h[0:4095];
  bit ce1_h[0:4095];

  // Reference state: phase, rate, pending write, wraps since last write.
  int m_acc[N], m_inc[N], m_pinc[N], m_wraps[N];
  bit m_pv[N];
  logic [N-1:0] e_ce, e_clk;
  logic         e_err;
  int rst_inc[N] = '{64, 32, 128};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_acc[c] = 0; m_inc[c] = rst_inc[c]; m_pinc[c] = 0; m_wraps[c] = 0; m_pv[c] = 0;
    end
    e_ce = '0; e_clk = '0; e_err = 1'b0;
  endtask

  task automatic model_step(input bit v, input int ch, input int inc, input bit rdy);
    for (int c = 0; c < N; c++) begin
      int nxt = m_acc[c] + m_inc[c];
      bit wrap = (m_inc[c] != 0) && (nxt >= 256);
      bit was_pend = m_pv[c];
      if (m_inc[c] != 0) begin
        m_acc[c] = nxt % 256;
        e_ce[c]  = wrap;
        e_clk[c] = (m_acc[c] >= 128);
      end else begin
        e_ce[c] = 1'b0; e_clk[c] = 1'b0;
      end
      if (was_pend && (wrap || m_inc[c] == 0)) begin
        if (m_pinc[c] == 0) begin
          m_acc[c] = 0; e_ce[c] = 1'b0; e_clk[c] = 1'b0;
        end
        m_inc[c] = m_pinc[c];
        m_pv[c]  = 0;
      end
      if (wrap && !was_pend && m_wraps[c] < 4) m_wraps[c]++;
      if (v && rdy && ch == c) begin
        m_pinc[c] = inc; m_pv[c] = 1; m_wraps[c] = 0;
      end
    end
    e_err = v && rdy && (ch >= N);
  endtask

  function automatic logic [N-1:0] exp_locked();
    logic [N-1:0] r;
    for (int c = 0; c < N; c++) r[c] = (m_wraps[c] == 4) && (m_inc[c] != 0);
    return r;
  endfunction

  task automatic tick(input bit v, input int ch, input int inc);
    bit rdy;
    logic [N-1:0] el;
    cfg_if.cfg_valid = v;
    cfg_if.cfg_ch    = 2'(ch);
    cfg_if.cfg_inc   = 8'(inc);
    #1;
    rdy = (ch >= N) ? 1'b1 : !m_pv[ch];
    chk("cfg_ready", 32'(cfg_if.cfg_ready), 32'(rdy));
    @(posedge refclk);
    edge_cnt++;
    model_step(v, ch, inc, rdy);
    #2;
    el = exp_locked();
    chk("ce_o", 32'(ce_o), 32'(e_ce));
    chk("clk_o", 32'(clk_o), 32'(e_clk));
    chk("locked", 32'(locked), 32'(el));
    chk("locked_all", 32'(locked_all), 32'(&el));
    chk("cfg_err", 32'(cfg_if.cfg_err), 32'(e_err));
    ce0_h[edge_cnt % 4096] = ce_o[0];
    ce1_h[edge_cnt % 4096] = ce_o[1];
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic wait_ch0_free(input int bound);
    for (int i = 0; i < bound && m_pv[0]; i++) tick(0, 0, 0);
    cfg_if.cfg_ch = 2'd0;
    #1;
    chk("ch0_slot_free", 32'(cfg_if.cfg_ready), 32'd1);
  endtask

  initial begin
    int first0, first_all, e0, r;
    logic [6:0] pat7;
    logic [5:0] pat6;
    logic [3:0] pat4;

    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_ch    = '0;
    cfg_if.cfg_inc   = '0;
    model_reset();

    chk("freq_to_inc", 32'(freq_to_inc(64'd50_000_000, 64'd20_000_000, 24)), 32'd6710886);

    #3;
    chk("rst_ce", 32'(ce_o), 32'd0);
    chk("rst_clk", 32'(clk_o), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_locked_all", 32'(locked_all), 32'd0);
    chk("rst_cfg_err", 32'(cfg_if.cfg_err), 32'd0);
    chk("rst_cfg_ready", 32'(cfg_if.cfg_ready), 32'd1);
    #24 rst_n = 1'b1;

    // Free-running from reset: lock timing of ch0 and aggregate.
    first0 = -1; first_all = -1;
    while (edge_cnt < 41) begin
      tick(0, 0, 0);
      if (locked[0] && first0 < 0) first0 = edge_cnt;
      if (locked_all && first_all < 0) first_all = edge_cnt;
    end
    chk("first_lock0_edge", 32'(first0), 32'd16);
    chk("first_lock_all_edge", 32'(first_all), 32'd32);
    for (int i = 0; i < 4; i++) pat4[3-i] = ce0_h[1+i];
    chk("ce0_first_period", 32'(pat4), 32'b0001);

    // Retune ch0 64->128 two edges after its wrap; refused second write; ch1 write meanwhile.
    tick(1, 0, 128);
    chk("lock0_drop_on_xfer", 32'(locked[0]), 32'd0);
    tick(1, 0, 32);
    tick(1, 1, 64);
    while (edge_cnt < 52) begin
      tick(0, 0, 0);
      if (edge_cnt >= 49) chk("lock0_relock", 32'(locked[0]), 32'(edge_cnt >= 52));
    end
    for (int i = 0; i < 6; i++) pat6[5-i] = ce0_h[43+i];
    chk("ce0_retune_pattern", 32'(pat6), 32'b010101);

    // Write landing on a ch0 carry edge.
    tick(0, 0, 0);
    tick(1, 0, 64);
    while (edge_cnt < 60) tick(0, 0, 0);
    for (int i = 0; i < 7; i++) pat7[6-i] = ce0_h[54+i];
    chk("ce0_same_edge_pattern", 32'(pat7), 32'b1010001);

    // Disable ch1, confirm quiet, then restart at 96.
    tick(1, 1, 0);
    for (int i = 0; i < 20 && m_pv[1]; i++) tick(0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tick(0, 0, 0);
      chk("ch1_disabled_quiet", 32'({ce_o[1], clk_o[1]}), 32'd0);
    end
    tick(1, 1, 96);
    e0 = edge_cnt;
    for (int i = 0; i < 4; i++) tick(0, 0, 0);
    for (int i = 0; i < 4; i++) pat4[3-i] = ce1_h[e0+1+i];
    chk("ch1_restart_pattern", 32'(pat4), 32'b0001);

    // Out-of-range channel.
    tick(1, 3, 77);
    chk("cfg_err_pulse", 32'(cfg_if.cfg_err), 32'd1);
    tick(0, 0, 0);
    chk("cfg_err_clear", 32'(cfg_if.cfg_err), 32'd0);

    // Random config traffic.
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(7);
      tick(($urandom_range(3) == 0), $urandom_range(3), (r == 0) ? 0 : $urandom_range(255));
    end

    // Park ch0 on a slow rate, leave a write pending, then reset.
    wait_ch0_free(600);
    tick(1, 0, 0);
    wait_ch0_free(600);
    tick(1, 0, 1);
    wait_ch0_free(10);
    tick(1, 0, 200);
    tick(0, 0, 0);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_ce", 32'(ce_o), 32'd0);
    chk("arst_clk", 32'(clk_o), 32'd0);
    chk("arst_locked", 32'(locked), 32'd0);
    chk("arst_locked_all", 32'(locked_all), 32'd0);
    chk("arst_cfg_err", 32'(cfg_if.cfg_err), 32'd0);
    chk("arst_cfg_ready", 32'(cfg_if.cfg_ready), 32'd1);
    @(posedge refclk);
    @(posedge refclk);
    #3 rst_n = 1'b1;
    edge_cnt = 0;
    first0 = -1;
    for (int i = 0; i < 40; i++) begin
      tick(0, 0, 0);
      if (ce_o[0] && first0 < 0) first0 = edge_cnt;
    end
    chk("post_arst_first_ce0", 32'(first0), 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
